// File: rtl/plot_pkg.sv
// Shared definitions for the trace plotter: pixel codes, screen geometry and FSM states.
package plot_pkg;

    localparam logic [1:0] PIX_WHITE   = 2'b00;
    localparam logic [1:0] PIX_TRACE1  = 2'b01;
    localparam logic [1:0] PIX_TRACE2  = 2'b10;
    localparam logic [1:0] PIX_SPECIAL = 2'b11;

    localparam int SCREEN_WIDTH  = 640;
    localparam int SCREEN_HEIGHT = 480;

    typedef enum logic [2:0] {
        ST_CLEAR_ALL,
        ST_IDLE,
        ST_CLEAR_COL,
        ST_PLOT1,
        ST_PLOT2,
        ST_ADVANCE
    } state_t;

endpackage

// File: rtl/y_scaler.sv
// Maps a signed 2.16 position to a screen row: CENTER_Y - (x >>> SCALE_SHIFT), clamped to the screen.
module y_scaler
    import plot_pkg::*;
#(
    parameter int SCALE_SHIFT = 9,
    parameter int CENTER_Y    = 240
) (
    input  logic signed [17:0] i_x,
    output logic        [8:0]  o_y
);

    localparam logic signed [18:0] C_CENTER  = 19'(CENTER_Y);
    localparam logic signed [18:0] C_MAX_ROW = 19'(SCREEN_HEIGHT - 1);

    logic signed [18:0] w_x_ext;
    logic signed [18:0] w_shifted;
    logic signed [18:0] w_y;

    assign w_x_ext   = {i_x[17], i_x};
    assign w_shifted = w_x_ext >>> SCALE_SHIFT;
    assign w_y       = C_CENTER - w_shifted;

    always_comb begin
        if (w_y < 19'sd0) begin
            o_y = 9'd0;
        end else if (w_y > C_MAX_ROW) begin
            o_y = C_MAX_ROW[8:0];
        end else begin
            o_y = w_y[8:0];
        end
    end

endmodule

// File: rtl/trace_plotter.sv
// Sweeps a time column across the display, erasing ahead of the trace and plotting two oscillator rows.
// Build option: define TRACE_PLOTTER_AXIS_EN to draw the zero axis (code 11) at row CENTER_Y while clearing.
module trace_plotter
    import plot_pkg::*;
#(
    parameter int SCALE_SHIFT = 9,
    parameter int CENTER_Y    = 240,
    parameter int DECIM       = 1,
    parameter int H_PIXELS    = SCREEN_WIDTH
) (
    input  logic               VGA_CTRL_CLK,
    input  logic               reset,
    input  logic               clr,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic signed [17:0] s_x1,
    input  logic signed [17:0] s_x2,
    output logic        [9:0]  wr_x,
    output logic        [8:0]  wr_y,
    output logic        [1:0]  wr_data,
    output logic               wr_en,
    output logic               busy
);

    localparam logic [9:0] C_LAST_COL   = 10'(H_PIXELS - 1);
    localparam logic [8:0] C_LAST_ROW   = 9'(SCREEN_HEIGHT - 1);
    localparam logic [7:0] C_DECIM_LAST = 8'(DECIM - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic        [9:0]  r_col;
    logic        [9:0]  w_col_nxt;
    logic        [8:0]  r_row;
    logic        [8:0]  w_row_nxt;
    logic        [7:0]  r_decim;
    logic        [7:0]  w_decim_nxt;
    logic signed [17:0] r_x1;
    logic signed [17:0] r_x2;

    logic               w_hs;
    logic               w_latch;
    logic               w_wr_en;
    logic        [8:0]  w_wr_y;
    logic        [1:0]  w_wr_data;
    logic        [1:0]  w_clear_pix;
    logic        [8:0]  w_y1;
    logic        [8:0]  w_y2;

    y_scaler #(.SCALE_SHIFT(SCALE_SHIFT), .CENTER_Y(CENTER_Y)) u_scale_x1 (
        .i_x (r_x1),
        .o_y (w_y1)
    );

    y_scaler #(.SCALE_SHIFT(SCALE_SHIFT), .CENTER_Y(CENTER_Y)) u_scale_x2 (
        .i_x (r_x2),
        .o_y (w_y2)
    );

    assign w_hs = s_valid & s_ready;

`ifdef TRACE_PLOTTER_AXIS_EN
    assign w_clear_pix = (r_row == 9'(CENTER_Y)) ? PIX_SPECIAL : PIX_WHITE;
`else
    assign w_clear_pix = PIX_WHITE;
`endif

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        w_state_nxt = r_state;
        w_col_nxt   = r_col;
        w_row_nxt   = r_row;
        w_decim_nxt = r_decim;
        w_latch     = 1'b0;
        w_wr_en     = 1'b0;
        w_wr_y      = r_row;
        w_wr_data   = PIX_WHITE;

        case (r_state)
            ST_CLEAR_ALL: begin
                w_wr_en   = 1'b1;
                w_wr_data = w_clear_pix;
                if (r_row == C_LAST_ROW) begin
                    w_row_nxt = 9'd0;
                    if (r_col == C_LAST_COL) begin
                        w_col_nxt   = 10'd0;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_col_nxt = r_col + 10'd1;
                    end
                end else begin
                    w_row_nxt = r_row + 9'd1;
                end
            end
            ST_IDLE: begin
                if (w_hs) begin
                    w_latch = 1'b1;
                    if (r_decim == C_DECIM_LAST) begin
                        w_decim_nxt = 8'd0;
                        w_row_nxt   = 9'd0;
                        w_state_nxt = ST_CLEAR_COL;
                    end else begin
                        w_decim_nxt = r_decim + 8'd1;
                    end
                end
            end
            ST_CLEAR_COL: begin
                w_wr_en   = 1'b1;
                w_wr_data = w_clear_pix;
                if (r_row == C_LAST_ROW) begin
                    w_row_nxt   = 9'd0;
                    w_state_nxt = ST_PLOT1;
                end else begin
                    w_row_nxt = r_row + 9'd1;
                end
            end
            ST_PLOT1: begin
                w_wr_en     = 1'b1;
                w_wr_y      = w_y1;
                w_wr_data   = PIX_TRACE1;
                w_state_nxt = ST_PLOT2;
            end
            ST_PLOT2: begin
                w_wr_en     = 1'b1;
                w_wr_y      = w_y2;
                w_wr_data   = PIX_TRACE2;
                w_state_nxt = ST_ADVANCE;
            end
            ST_ADVANCE: begin
                w_col_nxt   = (r_col == C_LAST_COL) ? 10'd0 : r_col + 10'd1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_CLEAR_ALL;
            end
        endcase

        // A clear request wins over everything, including a simultaneous handshake,
        // and suppresses the write this cycle would otherwise have produced.
        if (clr) begin
            w_state_nxt = ST_CLEAR_ALL;
            w_col_nxt   = 10'd0;
            w_row_nxt   = 9'd0;
            w_decim_nxt = 8'd0;
            w_latch     = 1'b0;
            w_wr_en     = 1'b0;
        end
    end

    always_ff @(posedge VGA_CTRL_CLK or posedge reset) begin
        if (reset) begin
            r_state <= ST_CLEAR_ALL;
            r_col   <= 10'd0;
            r_row   <= 9'd0;
            r_decim <= 8'd0;
            r_x1    <= '0;
            r_x2    <= '0;
            wr_en   <= 1'b0;
            wr_x    <= 10'd0;
            wr_y    <= 9'd0;
            wr_data <= PIX_WHITE;
            s_ready <= 1'b0;
            busy    <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            r_state <= w_state_nxt;
            r_col   <= w_col_nxt;
            r_row   <= w_row_nxt;
            r_decim <= w_decim_nxt;
            if (w_latch) begin
                r_x1 <= s_x1;
                r_x2 <= s_x2;
            end
            wr_en   <= w_wr_en;
            wr_x    <= r_col;
            wr_y    <= w_wr_y;
            wr_data <= w_wr_data;
            s_ready <= (w_state_nxt == ST_IDLE);
            busy    <= (w_state_nxt != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_trace_plotter.sv
// Directed bench for trace_plotter on a narrowed screen (16 columns, full 480 rows).
// Honours TRACE_PLOTTER_AXIS_EN when computing expected clear data.
module tb_trace_plotter;
    import plot_pkg::*;

    localparam int W    = 16;
    localparam int H    = SCREEN_HEIGHT;
    localparam int NCLR = W * H;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic        clr4;
    logic        s_valid;
    logic        s_valid4;
    logic [17:0] s_x1;
    logic [17:0] s_x2;

    logic        s_ready, wr_en, busy;
    logic [9:0]  wr_x;
    logic [8:0]  wr_y;
    logic [1:0]  wr_data;

    logic        s_ready4, wr_en4, busy4;
    logic [9:0]  wr_x4;
    logic [8:0]  wr_y4;
    logic [1:0]  wr_data4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    trace_plotter #(.SCALE_SHIFT(9), .CENTER_Y(240), .DECIM(1), .H_PIXELS(W)) dut (
        .VGA_CTRL_CLK (clk),
        .reset        (rst),
        .clr          (clr),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_x1         (s_x1),
        .s_x2         (s_x2),
        .wr_x         (wr_x),
        .wr_y         (wr_y),
        .wr_data      (wr_data),
        .wr_en        (wr_en),
        .busy         (busy)
    );

    trace_plotter #(.SCALE_SHIFT(9), .CENTER_Y(240), .DECIM(4), .H_PIXELS(W)) dut4 (
        .VGA_CTRL_CLK (clk),
        .reset        (rst),
        .clr          (clr4),
        .s_valid      (s_valid4),
        .s_ready      (s_ready4),
        .s_x1         (s_x1),
        .s_x2         (s_x2),
        .wr_x         (wr_x4),
        .wr_y         (wr_y4),
        .wr_data      (wr_data4),
        .wr_en        (wr_en4),
        .busy         (busy4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] clear_pix(input int row);
`ifdef TRACE_PLOTTER_AXIS_EN
        return (row == 240) ? PIX_SPECIAL : PIX_WHITE;
`else
        return (row < 0) ? PIX_SPECIAL : PIX_WHITE;
`endif
    endfunction

    // Observes a complete full-screen clear starting at the next negedge.
    task automatic full_clear(input string tag);
        int n = 0, bad = 0, early = 0, fx = -1, fy = -1, lx = -1, ly = -1;
        bit seen_ready = 1'b0;
        for (int k = 0; k < NCLR + 40 && n < NCLR; k++) begin
            @(negedge clk);
            if (wr_en) begin
                if (n == 0) begin
                    fx = int'(wr_x);
                    fy = int'(wr_y);
                end
                if (wr_x !== 10'(n / H) || wr_y !== 9'(n % H) || wr_data !== clear_pix(n % H)) bad++;
                n++;
                lx = int'(wr_x);
                ly = int'(wr_y);
                if (n == NCLR && s_ready) seen_ready = 1'b1;
                else if (s_ready) early++;
            end else if (s_ready) begin
                early++;
            end
        end
        check({tag, "_count"}, n, NCLR);
        check({tag, "_first_x"}, fx, 0);
        check({tag, "_first_y"}, fy, 0);
        check({tag, "_order_data"}, bad, 0);
        check({tag, "_last_x"}, lx, W - 1);
        check({tag, "_last_y"}, ly, H - 1);
        check({tag, "_ready_early"}, early, 0);
        @(negedge clk);
        if (s_ready) seen_ready = 1'b1;
        check({tag, "_no_col_write"}, wr_en, 0);
        check({tag, "_ready_rise"}, seen_ready, 1);
    endtask

    // Starts at the negedge one cycle after the handshake edge.
    task automatic observe_sample(input string tag, input logic [9:0] col,
                                  input logic [8:0] y1, input logic [8:0] y2);
        int n = 0, bad = 0, ready_bad = 0;
        logic [9:0] p1x = '0, p2x = '0;
        logic [8:0] p1y = '0, p2y = '0;
        logic [1:0] p1d = '0, p2d = '0;
        for (int k = 1; k <= 484; k++) begin
            if (k > 1) @(negedge clk);
            if (k < 484 && s_ready) ready_bad++;
            if (wr_en) begin
                if (k != n + 2) bad++;
                if (n < H) begin
                    if (wr_x !== col || wr_y !== 9'(n) || wr_data !== clear_pix(n)) bad++;
                end else if (n == H) begin
                    p1x = wr_x; p1y = wr_y; p1d = wr_data;
                end else if (n == H + 1) begin
                    p2x = wr_x; p2y = wr_y; p2d = wr_data;
                end else begin
                    bad++;
                end
                n++;
            end
        end
        check({tag, "_nwrites"}, n, H + 2);
        check({tag, "_clear_col"}, bad, 0);
        check({tag, "_p1_x"}, p1x, col);
        check({tag, "_p1_y"}, p1y, y1);
        check({tag, "_p1_data"}, p1d, PIX_TRACE1);
        check({tag, "_p2_x"}, p2x, col);
        check({tag, "_p2_y"}, p2y, y2);
        check({tag, "_p2_data"}, p2d, PIX_TRACE2);
        check({tag, "_ready_low"}, ready_bad, 0);
        check({tag, "_ready_back"}, s_ready, 1);
    endtask

    task automatic wait_ready(input string tag);
        int k = 0;
        while (!s_ready && k < 600) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_ready"}, s_ready, 1);
    endtask

    task automatic do_sample(input string tag, input logic [17:0] x1, input logic [17:0] x2,
                             input logic [9:0] col, input logic [8:0] y1, input logic [8:0] y2);
        wait_ready(tag);
        s_valid = 1'b1;
        s_x1    = x1;
        s_x2    = x2;
        @(negedge clk);
        s_valid = 1'b0;
        observe_sample(tag, col, y1, y2);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs = 0, nw = 0, nt1 = 0, hs_first = -1;
        logic [9:0] cols [2];
        cols[0] = '1;
        cols[1] = '1;

        rst      = 1'b1;
        clr      = 1'b0;
        clr4     = 1'b0;
        s_valid  = 1'b1;
        s_valid4 = 1'b0;
        s_x1     = 18'h0_8000;
        s_x2     = 18'h3_8000;
        repeat (3) @(negedge clk);
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_x", wr_x, 0);
        check("rst_wr_y", wr_y, 0);
        check("rst_wr_data", wr_data, PIX_WHITE);
        check("rst_s_ready", s_ready, 0);
        check("rst_busy", busy, 1);

        rst = 1'b0;
        full_clear("rst_clear");
        s_valid = 1'b0;
        observe_sample("first", 10'd0, 9'd176, 9'd304);

        do_sample("sat", 18'h1_FFFF, 18'h2_0000, 10'd1, 9'd0, 9'd479);
        do_sample("overlap", 18'h0, 18'h0, 10'd2, 9'd240, 9'd240);
        for (int c = 3; c < W; c++) begin
            do_sample("fill", 18'(c * 512), 18'(-(c * 512)), 10'(c), 9'(240 - c), 9'(240 + c));
        end
        do_sample("wrap", 18'h0, 18'h0, 10'd0, 9'd240, 9'd240);

        // clr in the middle of a column clear
        wait_ready("clr_mid");
        s_valid = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
        repeat (100) @(negedge clk);
        check("clr_mid_busy", busy, 1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clr_mid_s_ready", s_ready, 0);
        check("clr_mid_no_write", wr_en, 0);
        full_clear("clr_clear");
        do_sample("post_clr", 18'h0_8000, 18'h3_8000, 10'd0, 9'd176, 9'd304);

        // clr beats a simultaneous handshake
        s_valid = 1'b1;
        clr     = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
        clr     = 1'b0;
        check("clr_hs_s_ready", s_ready, 0);
        check("clr_hs_busy", busy, 1);
        full_clear("clr_hs_clear");

        // DECIM=4 instance: 8 handshakes give two sweeps at columns 0 and 1
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (wr_en4) begin
                nw++;
                if (hs_first < 0) hs_first = hs;
                if (wr_data4 == PIX_TRACE1) begin
                    if (nt1 < 2) cols[nt1] = wr_x4;
                    nt1++;
                end
            end
            s_valid4 = (hs < 8);
            if (s_valid4 && s_ready4) hs++;
        end
        s_valid4 = 1'b0;
        check("decim_handshakes", hs, 8);
        check("decim_first_after", hs_first, 4);
        check("decim_writes", nw, 2 * (H + 2));
        check("decim_sweeps", nt1, 2);
        check("decim_col0", cols[0], 0);
        check("decim_col1", cols[1], 1);

        // reset in the middle of a column clear aborts immediately
        wait_ready("rst_mid");
        s_valid = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
        repeat (50) @(negedge clk);
        check("rst_mid_writing", wr_en, 1);
        rst = 1'b1;
        #1;
        check("rst_mid_wr_en", wr_en, 0);
        check("rst_mid_s_ready", s_ready, 0);
        check("rst_mid_busy", busy, 1);
        check("rst_mid_wr_x", wr_x, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
